// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// phase_sequencer -- steps through NUM_PHASES phases with start/done handshakes,
// looping for a programmable iteration count. Optional watchdog: PHASE_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module phase_sequencer #(
    parameter int NUM_PHASES = 5,
    parameter int STATE_W    = 3,
    parameter int ITER_W     = 16,
    parameter int TIMEOUT_W  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_finish,
    input  logic [ITER_W-1:0]     i_iter_limit,
    input  logic [NUM_PHASES-1:0] i_phase_done,
    output logic [STATE_W-1:0]    o_state,
    output logic [NUM_PHASES-1:0] o_phase_start,
    output logic [ITER_W-1:0]     o_iter_cnt,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    localparam logic [STATE_W-1:0] c_IDLE  = '0;
    localparam logic [STATE_W-1:0] c_FIRST = STATE_W'(1);
    localparam logic [STATE_W-1:0] c_LAST  = STATE_W'(NUM_PHASES);
    localparam logic [STATE_W-1:0] c_DONE  = STATE_W'(NUM_PHASES + 1);
    localparam logic [STATE_W-1:0] c_ERR   = STATE_W'(NUM_PHASES + 2);

    logic [STATE_W-1:0]    r_state;
    logic [NUM_PHASES-1:0] r_phase_start;
    logic [ITER_W-1:0]     r_iter_cnt;
    logic [ITER_W-1:0]     r_limit;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;

    logic                  w_in_phase;
    logic                  w_ack;
    logic                  w_enter;
    logic                  w_timeout;
    logic [STATE_W-1:0]    w_next_state;
    logic [ITER_W-1:0]     w_next_iter;
    logic [ITER_W-1:0]     w_next_limit;
    logic [ITER_W-1:0]     w_iter_inc;
    logic [NUM_PHASES-1:0] w_start_vec;

    assign w_in_phase = (r_state >= c_FIRST) && (r_state <= c_LAST);
    assign w_iter_inc = r_iter_cnt + ITER_W'(1);

    // Only the current phase's acknowledge is looked at.
    always_comb begin
        w_ack = 1'b0;
        for (int p = 1; p <= NUM_PHASES; p++) begin
            if (r_state == STATE_W'(p)) begin
                w_ack = i_phase_done[p-1];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_enter      = 1'b0;
        w_next_iter  = r_iter_cnt;
        w_next_limit = r_limit;
        if ((r_state == c_IDLE) || (r_state == c_DONE) || (r_state == c_ERR)) begin
            if (i_start) begin
                w_next_state = c_FIRST;
                w_enter      = 1'b1;
                w_next_iter  = '0;
                w_next_limit = i_iter_limit;
            end
        end else if (w_in_phase) begin
            if (i_finish) begin
                w_next_state = c_DONE;
            end else if (w_ack) begin
                if (r_state == c_LAST) begin
                    w_next_iter = w_iter_inc;
                    if ((r_limit != '0) && (w_iter_inc == r_limit)) begin
                        w_next_state = c_DONE;
                    end else begin
                        w_next_state = c_FIRST;
                        w_enter      = 1'b1;
                    end
                end else begin
                    w_next_state = r_state + c_FIRST;
                    w_enter      = 1'b1;
                end
            end else if (w_timeout) begin
                w_next_state = c_ERR;
            end
        end else begin
            w_next_state = c_IDLE;
        end
    end

    // A pulse fires on every phase entry, including phase 1 re-entry on loop-back.
    always_comb begin
        w_start_vec = '0;
        for (int p = 1; p <= NUM_PHASES; p++) begin
            w_start_vec[p-1] = w_enter && (w_next_state == STATE_W'(p));
        end
    end

`ifdef PHASE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_wd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd <= '0;
        end else if (w_in_phase && !w_enter && (w_next_state == r_state)) begin
            r_wd <= r_wd + TIMEOUT_W'(1);
        end else begin
            r_wd <= '0;
        end
    end

    assign w_timeout = w_in_phase && (&r_wd) && !w_ack && !i_finish;
`else
    if (TIMEOUT_W > 0) begin : g_no_watchdog
        assign w_timeout = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_phase_start <= '0;
            r_iter_cnt    <= '0;
            r_limit       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_phase_start <= w_start_vec;
            r_iter_cnt    <= w_next_iter;
            r_limit       <= w_next_limit;
            r_busy        <= (w_next_state >= c_FIRST) && (w_next_state <= c_LAST);
            r_done        <= (w_next_state == c_DONE);
            r_error       <= (w_next_state == c_ERR);
        end
    end

    assign o_state       = r_state;
    assign o_phase_start = r_phase_start;
    assign o_iter_cnt    = r_iter_cnt;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_error       = r_error;

endmodule
`default_nettype wire
